text_console_writer: RTL



---
 rtl/text_console_writer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/text_console_writer.sv
// Character-stream writer for the tile-map RAM: turns ASCII bytes into single-cycle
// tile writes and tracks the text cursor. Optional per-row auto-clear: TEXT_AUTO_CLEAR_EN.
module text_console_writer #(
    parameter int COLS  = 32,
    parameter int ROWS  = 32,
    parameter int COL_W = $clog2(COLS),
    parameter int ROW_W = $clog2(ROWS)
) (
    input  logic                   i_pix_clk,
    input  logic                   i_reset,
    input  logic [7:0]             i_char,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic                   o_wr_en,
    output logic [ROW_W+COL_W-1:0] o_wr_addr,
    output logic [7:0]             o_wr_data,
    output logic [COL_W-1:0]       o_cursor_col,
    output logic [ROW_W-1:0]       o_cursor_row
);
    localparam int AW = ROW_W + COL_W;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_CLEAR_LINE = 2'd1,
        S_CLEAR_ALL  = 2'd2
    } state_t;

    state_t           r_state, w_state_next;
    logic [AW-1:0]    r_clr_cnt, w_clr_cnt_next;
    logic [COL_W-1:0] r_col, w_col_next;
    logic [ROW_W-1:0] r_row, w_row_next;
    logic             r_ready, w_ready_next;
    logic             r_wr_en, w_wr_en_next;
    logic [AW-1:0]    r_wr_addr, w_wr_addr_next;
    logic [7:0]       r_wr_data, w_wr_data_next;

    logic             w_accept;
    logic             w_printable, w_is_lf, w_is_cr, w_is_bs, w_is_ff;
    logic             w_col_last;
    logic [COL_W-1:0] w_col_dec;
    logic [ROW_W-1:0] w_row_inc;
    logic             w_clr_last_all;

    // r_ready is only ever set while in IDLE, so it alone qualifies acceptance
    assign w_accept       = i_valid && r_ready;
    assign w_printable    = (i_char >= 8'h20) && (i_char <= 8'h7E);
    assign w_is_lf        = (i_char == 8'h0A);
    assign w_is_cr        = (i_char == 8'h0D);
    assign w_is_bs        = (i_char == 8'h08);
    assign w_is_ff        = (i_char == 8'h0C);
    assign w_col_last     = (r_col == COL_W'(COLS - 1));
    assign w_col_dec      = r_col - 1'b1;
    assign w_row_inc      = r_row + 1'b1;
    assign w_clr_last_all = (r_clr_cnt == AW'(COLS * ROWS - 1));

`ifdef TEXT_AUTO_CLEAR_EN
    logic w_advance;
    logic w_clr_last_line;
    assign w_advance       = w_accept && ((w_printable && w_col_last) || w_is_lf);
    assign w_clr_last_line = (r_clr_cnt[COL_W-1:0] == COL_W'(COLS - 1));
`endif

    always_ff @(posedge i_pix_clk) begin
        if (i_reset) begin
            r_state   <= S_CLEAR_ALL;
            r_clr_cnt <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_ready   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 8'h00;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
            r_col     <= w_col_next;
            r_row     <= w_row_next;
            r_ready   <= w_ready_next;
            r_wr_en   <= w_wr_en_next;
            r_wr_addr <= w_wr_addr_next;
            r_wr_data <= w_wr_data_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_ff) begin
                    w_state_next = S_CLEAR_ALL;
                end
`ifdef TEXT_AUTO_CLEAR_EN
                else if (w_advance) begin
                    w_state_next = S_CLEAR_LINE;
                end
`endif
            end
`ifdef TEXT_AUTO_CLEAR_EN
            S_CLEAR_LINE: begin
                if (w_clr_last_line) w_state_next = S_IDLE;
            end
`endif
            S_CLEAR_ALL: begin
                if (w_clr_last_all) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Registered-output next values; address/data hold unless a write is issued
    always_comb begin
        w_clr_cnt_next = r_clr_cnt;
        w_col_next     = r_col;
        w_row_next     = r_row;
        w_ready_next   = 1'b0;
        w_wr_en_next   = 1'b0;
        w_wr_addr_next = r_wr_addr;
        w_wr_data_next = r_wr_data;
        case (r_state)
            S_IDLE: begin
                w_ready_next   = 1'b1;
                w_clr_cnt_next = '0;
                if (w_accept) begin
                    if (w_printable) begin
                        w_wr_en_next   = 1'b1;
                        w_wr_addr_next = {r_row, r_col};
                        w_wr_data_next = i_char;
                        if (w_col_last) begin
                            w_col_next = '0;
                            w_row_next = w_row_inc;
                        end else begin
                            w_col_next = r_col + 1'b1;
                        end
                    end else if (w_is_lf) begin
                        w_col_next = '0;
                        w_row_next = w_row_inc;
                    end else if (w_is_cr) begin
                        w_col_next = '0;
                    end else if (w_is_bs) begin
                        if (r_col != '0) begin
                            w_col_next     = w_col_dec;
                            w_wr_en_next   = 1'b1;
                            w_wr_addr_next = {r_row, w_col_dec};
                            w_wr_data_next = 8'h20;
                        end
                    end else if (w_is_ff) begin
                        w_col_next   = '0;
                        w_row_next   = '0;
                        w_ready_next = 1'b0;
                    end
`ifdef TEXT_AUTO_CLEAR_EN
                    if (w_advance) w_ready_next = 1'b0;
`endif
                end
            end
`ifdef TEXT_AUTO_CLEAR_EN
            S_CLEAR_LINE: begin
                w_wr_en_next   = 1'b1;
                w_wr_addr_next = {r_row, r_clr_cnt[COL_W-1:0]};
                w_wr_data_next = 8'h20;
                w_clr_cnt_next = w_clr_last_line ? '0 : r_clr_cnt + 1'b1;
            end
`endif
            S_CLEAR_ALL: begin
                w_wr_en_next   = 1'b1;
                w_wr_addr_next = r_clr_cnt;
                w_wr_data_next = 8'h20;
                w_clr_cnt_next = w_clr_last_all ? '0 : r_clr_cnt + 1'b1;
                w_col_next     = '0;
                w_row_next     = '0;
            end
            default: ;
        endcase
    end

    assign o_ready      = r_ready;
    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_cursor_col = r_col;
    assign o_cursor_row = r_row;

endmodule
